// File: rtl/demux1to4_seq.sv
// Registered 1-to-4 demux: routes one word into one of four holding
// registers, chosen by sel or by a round-robin pointer.
module demux1to4_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in,
  input  logic [1:0]         sel,
  input  logic               mode,
  input  logic [3:0]         ack,
  output logic [4*WIDTH-1:0] out,
  output logic [3:0]         out_valid,
  output logic [1:0]         ptr
);

  logic [1:0] tgt;
  logic       acc;

  assign tgt      = mode ? ptr : sel;
  assign in_ready = ~out_valid[tgt] | ack[tgt];
  assign acc      = in_valid & in_ready;

  // A load into a channel overrides its own ack in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= '0;
      ptr       <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc && (tgt == 2'(i))) begin
          out[i*WIDTH +: WIDTH] <= in;
          out_valid[i]          <= 1'b1;
        end else if (ack[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
      if (acc && mode)
        ptr <= ptr + 2'd1;
    end
  end

endmodule

// File: tb/tb_demux1to4_seq.sv
// Randomized and directed bench for demux1to4_seq against an
// array-based reference model of the four channels.
module tb_demux1to4_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in;
  logic [1:0]  sel;
  logic        mode;
  logic [3:0]  ack;
  logic [15:0] out;
  logic [3:0]  out_valid;
  logic [1:0]  ptr;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] m_dat [4];
  bit         m_vld [4];
  int         m_ptr;

  demux1to4_seq #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .sel       (sel),
    .mode      (mode),
    .ack       (ack),
    .out       (out),
    .out_valid (out_valid),
    .ptr       (ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_dat[i] = '0;
      m_vld[i] = 1'b0;
    end
    m_ptr = 0;
  endfunction

  function automatic int m_tgt(input bit m, input int s);
    return m ? m_ptr : s;
  endfunction

  function automatic bit m_rdy(input bit m, input int s,
                               input logic [3:0] a);
    int t;
    t = m_tgt(m, s);
    return !m_vld[t] || a[t];
  endfunction

  function automatic logic [15:0] m_out();
    logic [15:0] o;
    for (int i = 0; i < 4; i++) o[i*4 +: 4] = m_dat[i];
    return o;
  endfunction

  function automatic logic [3:0] m_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_vld[i];
    return v;
  endfunction

  task automatic step(input bit iv, input logic [3:0] d,
                      input int s, input bit m,
                      input logic [3:0] a);
    bit rdy;
    int t;
    @(negedge clk);
    in_valid = iv;
    in       = d;
    sel      = 2'(s);
    mode     = m;
    ack      = a;
    #1;
    rdy = m_rdy(m, s, a);
    t   = m_tgt(m, s);
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (iv && rdy && i == t) begin
        m_dat[i] = d;
        m_vld[i] = 1'b1;
      end else if (a[i]) begin
        m_vld[i] = 1'b0;
      end
    end
    if (iv && rdy && m) m_ptr = (m_ptr + 1) % 4;
    #1;
    chk("out", {16'd0, out}, {16'd0, m_out()});
    chk("out_valid", {28'd0, out_valid}, {28'd0, m_valid()});
    chk("ptr", {30'd0, ptr}, m_ptr);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in = 0; sel = 0; mode = 0; ack = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {16'd0, out}, 32'd0);
    chk("rst_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_ptr", {30'd0, ptr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // direct load
    step(1, 4'hA, 2, 0, 4'b0000);
    chk("dl_slice", {28'd0, out[11:8]}, 32'hA);
    chk("dl_valid", {28'd0, out_valid}, 32'b0100);
    chk("dl_other", {16'd0, out[15:12], 4'h0, out[7:0]}, 32'd0);

    // backpressure then same-cycle replace
    step(1, 4'h5, 2, 0, 4'b0000);
    chk("bp_hold", {28'd0, out[11:8]}, 32'hA);
    step(1, 4'h5, 2, 0, 4'b0100);
    chk("bp_repl", {28'd0, out[11:8]}, 32'h5);
    chk("bp_vld", {31'd0, out_valid[2]}, 32'd1);
    step(0, 0, 0, 0, 4'b0100);

    // round robin, stall on full channel 0
    for (int k = 1; k <= 4; k++) step(1, 4'(k), 0, 1, 4'b0000);
    chk("rr_full", {28'd0, out_valid}, 32'hF);
    chk("rr_data", {16'd0, out}, 32'h4321);
    step(1, 4'h9, 3, 1, 4'b0000);
    step(1, 4'h9, 3, 1, 4'b0000);
    chk("rr_stall", {28'd0, out[3:0]}, 32'h1);
    step(1, 4'h9, 3, 1, 4'b0001);
    chk("rr_ack", {28'd0, out[3:0]}, 32'h9);
    step(0, 0, 0, 0, 4'b1111);

    // sweep
    for (int s = 0; s < 4; s++)
      for (int d = 0; d < 16; d++) begin
        step(1, 4'(d), s, 0, 4'b0000);
        step(0, 0, 0, 0, 4'(1 << s));
      end
    chk("sw_empty", {28'd0, out_valid}, 32'd0);

    // idle ack, then ack ch1 alongside load ch3
    step(0, 0, 0, 0, 4'b1111);
    step(1, 4'h7, 1, 0, 4'b0000);
    step(1, 4'hC, 3, 0, 4'b0010);
    chk("ak_ch1", {31'd0, out_valid[1]}, 32'd0);
    chk("ak_ch3", {31'd0, out_valid[3]}, 32'd1);
    chk("ak_hold", {28'd0, out[7:4]}, 32'h7);

    // random traffic
    for (int k = 0; k < 400; k++)
      step($urandom % 4 != 0, 4'($urandom), $urandom % 4,
           1'($urandom), ($urandom % 3 == 0) ? 4'($urandom) : 4'b0000);

    // build out_valid=1111, ptr=2, then reset mid-run
    step(0, 0, 0, 0, 4'b1111);
    while (m_ptr != 0) step(1, 4'h1, 0, 1, 4'b1111);
    step(0, 0, 0, 0, 4'b1111);
    step(1, 4'h3, 0, 1, 4'b0000);
    step(1, 4'h6, 0, 1, 4'b0000);
    step(1, 4'hB, 2, 0, 4'b0000);
    step(1, 4'hE, 3, 0, 4'b0000);
    chk("pre_valid", {28'd0, out_valid}, 32'hF);
    chk("pre_ptr", {30'd0, ptr}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out", {16'd0, out}, 32'd0);
    chk("ar_valid", {28'd0, out_valid}, 32'd0);
    chk("ar_ptr", {30'd0, ptr}, 32'd0);
    in_valid = 1'b1; in = 4'hF; mode = 1'b0; sel = 2'd1; ack = 0;
    @(posedge clk);
    #1;
    chk("ar_held", {28'd0, out_valid}, 32'd0);
    m_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("ar_ready", {31'd0, in_ready}, 32'd1);
    step(1, 4'h8, 1, 0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
